light_dance_gen: RTL and testbench

Parametrised successor to the 8-bit light-dance shift register in the SmartHome light path. It drives a WIDTH-bit LED bank from a parallel-loaded pattern and advances it at a programmable rate in one of four modes:
- shift left
- shift right
- rotate
- bounce (ping-pong)

It sits between the SmartHome control registers (pattern, mode, rate) and the LED output pins.

---
 rtl/light_dance_gen.sv | 91 +++++++++
 tb/tb_light_dance_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/light_dance_gen.sv
// Programmable-rate LED pattern generator: parallel load, then shift-left,
// shift-right, rotate-left or bounce at a rate set by a prescaler divider.
module light_dance_gen #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] pdata,
    input  logic             din,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] qdata,
    output logic             step,
    output logic             dir
);

    typedef enum logic [1:0] {
        MODE_SHL    = 2'b00,
        MODE_SHR    = 2'b01,
        MODE_ROL    = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_t;

    localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt;
    logic             at_top;
    logic             tick;
    logic [WIDTH-1:0] next_q;
    logic             next_dir;
    mode_t            mode_sel;

    assign mode_sel = mode_t'(mode);
    assign at_top   = (cnt == div);
    assign tick     = en & ~load & at_top;

    // Bounce holds when there is nothing to move or when both ends are lit,
    // since either direction would immediately push a light off the bank.
    always_comb begin
        next_q   = qdata;
        next_dir = dir;
        case (mode_sel)
            MODE_SHL: next_q = {qdata[WIDTH-2:0], din};
            MODE_SHR: next_q = {din, qdata[WIDTH-1:1]};
            MODE_ROL: next_q = {qdata[WIDTH-2:0], qdata[WIDTH-1]};
            MODE_BOUNCE: begin
                if (qdata == '0 || (qdata[WIDTH-1] && qdata[0])) begin
                    next_q = qdata;
                end else if (!dir && qdata[WIDTH-1]) begin
                    next_dir = 1'b1;
                    next_q   = {1'b0, qdata[WIDTH-1:1]};
                end else if (dir && qdata[0]) begin
                    next_dir = 1'b0;
                    next_q   = {qdata[WIDTH-2:0], 1'b0};
                end else if (dir) begin
                    next_q = {1'b0, qdata[WIDTH-1:1]};
                end else begin
                    next_q = {qdata[WIDTH-2:0], 1'b0};
                end
            end
            default: next_q = qdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            qdata <= '0;
            cnt   <= '0;
            dir   <= 1'b0;
            step  <= 1'b0;
        end else if (load) begin
            qdata <= pdata;
            cnt   <= '0;
            dir   <= 1'b0;
            step  <= 1'b0;
        end else begin
            step <= tick;
            if (en) begin
                cnt <= at_top ? '0 : cnt + CNT_ONE;
            end
            if (tick) begin
                qdata <= next_q;
                dir   <= next_dir;
            end
        end
    end

endmodule

// File: tb/tb_light_dance_gen.sv
// Directed bench for light_dance_gen: an 8-bit instance covering every mode and
// collision case, plus a 4-bit instance for the rotate wrap.
module tb_light_dance_gen;

    logic        clk = 1'b0;
    logic        arst, en, load, din;
    logic [7:0]  pdata;
    logic [1:0]  mode;
    logic [15:0] div;
    logic [7:0]  qdata;
    logic        step, dir;

    logic        arst4, en4, load4, din4;
    logic [3:0]  pdata4;
    logic [1:0]  mode4;
    logic [15:0] div4;
    logic [3:0]  qdata4;
    logic        step4, dir4;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_seq [$];

    always #5 clk = ~clk;

    light_dance_gen #(.WIDTH(8), .DIV_W(16)) dut (
        .clk(clk), .arst(arst), .en(en), .load(load), .pdata(pdata), .din(din),
        .mode(mode), .div(div), .qdata(qdata), .step(step), .dir(dir)
    );

    light_dance_gen #(.WIDTH(4), .DIV_W(16)) dut4 (
        .clk(clk), .arst(arst4), .en(en4), .load(load4), .pdata(pdata4), .din(din4),
        .mode(mode4), .div(div4), .qdata(qdata4), .step(step4), .dir(dir4)
    );

    // Drive the control strobes, then let one rising edge pass and settle.
    task automatic applyStimulus(input logic ld, input logic [7:0] pd, input logic e);
        load  = ld;
        pdata = pd;
        en    = e;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial begin
        arst = 1'b1; en = 1'b0; load = 1'b0; din = 1'b0; pdata = 8'h00;
        mode = 2'b00; div = 16'd0;
        arst4 = 1'b1; en4 = 1'b0; load4 = 1'b0; din4 = 1'b0; pdata4 = 4'h0;
        mode4 = 2'b10; div4 = 16'd0;

        // Reset and load
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("reset_q", 32'(qdata), 32'h00);
        checkOutput("reset_step", 32'(step), 32'h0);
        checkOutput("reset_dir", 32'(dir), 32'h0);
        arst = 1'b0;
        applyStimulus(1'b1, 8'hD5, 1'b0);
        checkOutput("load_q", 32'(qdata), 32'hD5);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            checkOutput("hold_q", 32'(qdata), 32'hD5);
            checkOutput("hold_step", 32'(step), 32'h0);
            checkOutput("hold_dir", 32'(dir), 32'h0);
        end

        // Shift-left, div=3: one advance every 4 cycles
        div = 16'd3; mode = 2'b00; din = 1'b1;
        applyStimulus(1'b1, 8'hD5, 1'b0);
        exp_seq = '{8'hAB, 8'h57, 8'hAF, 8'h5F};
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 3; c++) begin
                applyStimulus(1'b0, 8'h00, 1'b1);
                checkOutput("shl_wait_step", 32'(step), 32'h0);
            end
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("shl_q", 32'(qdata), 32'(exp_seq[s]));
            checkOutput("shl_step", 32'(step), 32'h1);
        end

        // Shift-right then rotate-left, div=0
        div = 16'd0; mode = 2'b01; din = 1'b0;
        applyStimulus(1'b1, 8'h81, 1'b1);
        checkOutput("shr_load_step", 32'(step), 32'h0);
        exp_seq = '{8'h40, 8'h20};
        for (int s = 0; s < 2; s++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("shr_q", 32'(qdata), 32'(exp_seq[s]));
            checkOutput("shr_step", 32'(step), 32'h1);
        end
        mode = 2'b10;
        exp_seq = '{8'h40, 8'h80, 8'h01};
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("rol_q", 32'(qdata), 32'(exp_seq[s]));
        end

        // Bounce from 03: out to C0, back down to 03, turn at 03
        mode = 2'b11;
        applyStimulus(1'b1, 8'h03, 1'b1);
        exp_seq = '{8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0,
                    8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h06};
        for (int s = 0; s < 13; s++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("bnc_q", 32'(qdata), 32'(exp_seq[s]));
            checkOutput("bnc_dir", 32'((s >= 6 && s <= 11) ? 1 : 0), 32'(dir));
        end
        applyStimulus(1'b1, 8'h81, 1'b1);
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("bnc81_q", 32'(qdata), 32'h81);
            checkOutput("bnc81_step", 32'(step), 32'h1);
            checkOutput("bnc81_dir", 32'(dir), 32'h0);
        end
        applyStimulus(1'b1, 8'h00, 1'b1);
        for (int s = 0; s < 2; s++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("bnc0_q", 32'(qdata), 32'h00);
            checkOutput("bnc0_step", 32'(step), 32'h1);
        end

        // Load on a tick cycle wins; then rotate resumes from the loaded value
        mode = 2'b10;
        applyStimulus(1'b1, 8'h3C, 1'b1);
        checkOutput("coll_load_q", 32'(qdata), 32'h3C);
        checkOutput("coll_load_step", 32'(step), 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("coll_next_q", 32'(qdata), 32'h78);

        // Reset mid-period with div=5 discards the partial count
        div = 16'd5;
        applyStimulus(1'b1, 8'h01, 1'b1);
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, 8'h00, 1'b1);
        arst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("arst_mid_q", 32'(qdata), 32'h00);
        checkOutput("arst_mid_step", 32'(step), 32'h0);
        arst = 1'b0;
        applyStimulus(1'b1, 8'h01, 1'b1);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("arst_wait_q", 32'(qdata), 32'h01);
            checkOutput("arst_wait_step", 32'(step), 32'h0);
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("arst_adv_q", 32'(qdata), 32'h02);
        checkOutput("arst_adv_step", 32'(step), 32'h1);

        // Enable gating freezes the prescaler mid-period
        div = 16'd3;
        applyStimulus(1'b1, 8'h01, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            checkOutput("en_frz_q", 32'(qdata), 32'h01);
            checkOutput("en_frz_step", 32'(step), 32'h0);
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("en_res1_q", 32'(qdata), 32'h01);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("en_res2_q", 32'(qdata), 32'h02);
        checkOutput("en_res2_step", 32'(step), 32'h1);

        // 4-bit instance rotate wrap
        arst4 = 1'b0; load4 = 1'b1; pdata4 = 4'b1000; en4 = 1'b1;
        @(posedge clk); #1;
        checkOutput("w4_load_q", 32'(qdata4), 32'h8);
        load4 = 1'b0;
        @(posedge clk); #1;
        checkOutput("w4_rol1_q", 32'(qdata4), 32'h1);
        @(posedge clk); #1;
        checkOutput("w4_rol2_q", 32'(qdata4), 32'h2);
        checkOutput("w4_step", 32'(step4), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
